// File: rtl/tpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : tpu_ctrl_pkg
// Description : Shared types and helpers for the TPU matmul sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tpu_ctrl_pkg;

    localparam int ARRAY_SIZE_DEF = 4;
    localparam int DIM_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // ceil(num / 2**lg); the array size is a power of two so a shift suffices
    function automatic logic [DIM_W-1:0] ceil_div_pow2(input logic [DIM_W-1:0] num,
                                                       input int               lg);
        logic [DIM_W:0] bias;
        logic [DIM_W:0] sum;
        bias = (DIM_W+1)'((1 << lg) - 1);
        sum  = {1'b0, num} + bias;
        return DIM_W'(sum >> lg);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : tpu_ctrl_if
// Description : Start/dims command and buffer/array control bundle of tpu_ctrl.
//               perf_cycles exists only when TPU_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tpu_ctrl_if
    import tpu_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ADDR_W     = 16
);
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic              start;
    logic [DIM_W-1:0]  row_a;
    logic [DIM_W-1:0]  k;
    logic [DIM_W-1:0]  col_b;
    logic [ADDR_W-1:0] index_a;
    logic [ADDR_W-1:0] index_b;
    logic              sa_clear;
    logic              sa_valid;
    logic [ROW_W-1:0]  sa_row_sel;
    logic              wr_en_out;
    logic [ADDR_W-1:0] index_out;
    logic              busy;
    logic              done;
`ifdef TPU_PERF_CNT_EN
    logic [31:0]       perf_cycles;

    modport master (output start, row_a, k, col_b,
                    input  index_a, index_b, sa_clear, sa_valid, sa_row_sel,
                           wr_en_out, index_out, busy, done, perf_cycles);
    modport slave  (input  start, row_a, k, col_b,
                    output index_a, index_b, sa_clear, sa_valid, sa_row_sel,
                           wr_en_out, index_out, busy, done, perf_cycles);
`else
    modport master (output start, row_a, k, col_b,
                    input  index_a, index_b, sa_clear, sa_valid, sa_row_sel,
                           wr_en_out, index_out, busy, done);
    modport slave  (input  start, row_a, k, col_b,
                    output index_a, index_b, sa_clear, sa_valid, sa_row_sel,
                           wr_en_out, index_out, busy, done);
`endif

endinterface

`default_nettype wire

// File: rtl/tpu_tile_iter.sv
//------------------------------------------------------------------------------
// Module      : tpu_tile_iter
// Description : Row-major tile walker; keeps running base indices for A, B, OUT.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_tile_iter
    import tpu_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ADDR_W     = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [DIM_W-1:0]  tiles_r_i,
    input  logic [DIM_W-1:0]  tiles_c_i,
    input  logic [DIM_W-1:0]  k_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] base_a_o,
    output logic [ADDR_W-1:0] base_b_o,
    output logic [ADDR_W-1:0] base_out_o
);

    logic [DIM_W-1:0]  tr_q;
    logic [DIM_W-1:0]  tc_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] base_out_q;
    logic              row_end;

    assign row_end = (tc_q == (tiles_c_i - DIM_W'(1)));
    assign last_o  = row_end && (tr_q == (tiles_r_i - DIM_W'(1)));

    // Bases advance by addition so no multiplier is needed for tr*K / tc*K
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_q       <= '0;
            tc_q       <= '0;
            base_a_q   <= '0;
            base_b_q   <= '0;
            base_out_q <= '0;
        end else if (load_i) begin
            tr_q       <= '0;
            tc_q       <= '0;
            base_a_q   <= '0;
            base_b_q   <= '0;
            base_out_q <= '0;
        end else if (adv_i) begin
            base_out_q <= base_out_q + ADDR_W'(ARRAY_SIZE);
            if (row_end) begin
                tc_q     <= '0;
                tr_q     <= tr_q + DIM_W'(1);
                base_b_q <= '0;
                base_a_q <= base_a_q + ADDR_W'(k_i);
            end else begin
                tc_q     <= tc_q + DIM_W'(1);
                base_b_q <= base_b_q + ADDR_W'(k_i);
            end
        end
    end

    assign base_a_o   = base_a_q;
    assign base_b_o   = base_b_q;
    assign base_out_o = base_out_q;

endmodule

`default_nettype wire

// File: rtl/tpu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tpu_ctrl
// Description : Tiled matmul sequencer driving GBUFF_A/B reads, systolic array
//               control and GBUFF_OUT writes. Optional TPU_PERF_CNT_EN adds
//               a saturating busy-cycle counter on bus.perf_cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ADDR_W     = 16
)(
    input  logic       clk,
    input  logic       rst_n,
    tpu_ctrl_if.slave  bus
);

    localparam int LG_N  = $clog2(ARRAY_SIZE);
    localparam int ROW_W = (ARRAY_SIZE > 1) ? LG_N : 1;
    localparam int CNT_W = $clog2(2 * ARRAY_SIZE + 16);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * ARRAY_SIZE - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(ARRAY_SIZE - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIM_W-1:0]  k_q, k_d;
    logic [DIM_W-1:0]  tiles_r_q, tiles_r_d;
    logic [DIM_W-1:0]  tiles_c_q, tiles_c_d;

    logic              sa_clear_q, sa_clear_d;
    logic              sa_valid_q, sa_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [ROW_W-1:0]  row_sel_q, row_sel_d;
    logic [ADDR_W-1:0] index_a_q, index_a_d;
    logic [ADDR_W-1:0] index_b_q, index_b_d;
    logic [ADDR_W-1:0] index_out_q, index_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              iter_load;
    logic              iter_adv;
    logic              last_tile;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_out;
    logic              dims_zero;

    assign dims_zero = (bus.row_a == '0) || (bus.k == '0) || (bus.col_b == '0);

    tpu_tile_iter #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ADDR_W     (ADDR_W)
    ) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (iter_load),
        .adv_i      (iter_adv),
        .tiles_r_i  (tiles_r_q),
        .tiles_c_i  (tiles_c_q),
        .k_i        (k_q),
        .last_o     (last_tile),
        .base_a_o   (base_a),
        .base_b_o   (base_b),
        .base_out_o (base_out)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        tiles_r_d = tiles_r_q;
        tiles_c_d = tiles_c_q;
        iter_load = 1'b0;
        iter_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    k_d       = bus.k;
                    tiles_r_d = ceil_div_pow2(bus.row_a, LG_N);
                    tiles_c_d = ceil_div_pow2(bus.col_b, LG_N);
                    iter_load = 1'b1;
                    state_d   = dims_zero ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (cnt_q == (CNT_W'(k_q) - CNT_W'(1))) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    cnt_d = '0;
                    if (last_tile) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_CLEAR;
                        iter_adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it
    always_comb begin
        sa_clear_d  = (state_d == ST_CLEAR);
        sa_valid_d  = (state_q == ST_FEED);
        wr_en_d     = (state_d == ST_WRITE);
        row_sel_d   = (state_d == ST_WRITE) ? cnt_d[ROW_W-1:0] : '0;
        index_a_d   = (state_d == ST_FEED)  ? base_a + ADDR_W'(cnt_d) : '0;
        index_b_d   = (state_d == ST_FEED)  ? base_b + ADDR_W'(cnt_d) : '0;
        index_out_d = (state_d == ST_WRITE) ? base_out + ADDR_W'(cnt_d) : '0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            tiles_r_q   <= '0;
            tiles_c_q   <= '0;
            sa_clear_q  <= 1'b0;
            sa_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            row_sel_q   <= '0;
            index_a_q   <= '0;
            index_b_q   <= '0;
            index_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            tiles_r_q   <= tiles_r_d;
            tiles_c_q   <= tiles_c_d;
            sa_clear_q  <= sa_clear_d;
            sa_valid_q  <= sa_valid_d;
            wr_en_q     <= wr_en_d;
            row_sel_q   <= row_sel_d;
            index_a_q   <= index_a_d;
            index_b_q   <= index_b_d;
            index_out_q <= index_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef TPU_PERF_CNT_EN
    logic [31:0] perf_q;

    // Counts the working states only, so a zero-dim launch reads back 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            perf_q <= '0;
        end else if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

    assign bus.index_a    = index_a_q;
    assign bus.index_b    = index_b_q;
    assign bus.sa_clear   = sa_clear_q;
    assign bus.sa_valid   = sa_valid_q;
    assign bus.sa_row_sel = row_sel_q;
    assign bus.wr_en_out  = wr_en_q;
    assign bus.index_out  = index_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tpu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_tpu_ctrl
// Description : Self-checking bench for tpu_ctrl (cycle model + vector table).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tpu_ctrl;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int RW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tpu_ctrl_if #(.ARRAY_SIZE(N), .ADDR_W(AW)) bus ();

    tpu_ctrl #(.ARRAY_SIZE(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          clr;
        logic          vld;
        logic          wr;
        logic [RW-1:0] row;
        logic [AW-1:0] ia;
        logic [AW-1:0] ib;
        logic [AW-1:0] io;
    } outs_t;

    typedef struct {
        int m; int k; int p; bit chg;
        int exp_done; int exp_writes; int exp_clears; int exp_busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic outs_t sample();
        outs_t s;
        s.busy = bus.busy;      s.done = bus.done;
        s.clr  = bus.sa_clear;  s.vld  = bus.sa_valid;
        s.wr   = bus.wr_en_out; s.row  = bus.sa_row_sel;
        s.ia   = bus.index_a;   s.ib   = bus.index_b;
        s.io   = bus.index_out;
        return s;
    endfunction

    function automatic int job_len(input int m, k, p);
        if (m == 0 || k == 0 || p == 0) return 0;
        return ((m + N - 1) / N) * ((p + N - 1) / N) * (1 + k + 3 * N);
    endfunction

    // Expected outputs c cycles after the start-sampling edge
    function automatic outs_t model(input int m, k, p, c);
        outs_t e;
        int tc_n, per, tot, t, o, r;
        e    = '0;
        tc_n = (p + N - 1) / N;
        per  = 1 + k + 3 * N;
        tot  = job_len(m, k, p);
        if (c < tot) begin
            t = c / per;
            o = c % per;
            e.busy = 1'b1;
            e.clr  = (o == 0);
            if (o >= 1 && o <= k) begin
                e.ia = AW'((t / tc_n) * k + o - 1);
                e.ib = AW'((t % tc_n) * k + o - 1);
            end
            e.vld = (o >= 2 && o <= k + 1);
            if (o >= 1 + k + 2 * N) begin
                r     = o - (1 + k + 2 * N);
                e.wr  = 1'b1;
                e.row = RW'(r);
                e.io  = AW'(t * N + r);
            end
        end else if (c == tot) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic check_outs(input string nm, input int c, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s c=%0d actual=%h required=%h", nm, c, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic run_job(input int m, k, p, input bit chg, hold, input int abort_at,
                           output int done_c, wr_n, clr_n, busy_n);
        int tot, last_c, seen;
        outs_t act;
        done_c = -1; wr_n = 0; clr_n = 0; busy_n = 0;
        tot    = job_len(m, k, p);
        last_c = (hold ? 2 : 1) * (tot + 2) - 1;
        @(posedge clk); #1;
        bus.row_a = 4'(m); bus.k = 4'(k); bus.col_b = 4'(p);
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) bus.start = 1'b0;
            if (hold && c == tot + 2) bus.start = 1'b0;
            if (chg && c == 3) begin
                bus.start = 1'b1; bus.row_a = 4'd15; bus.k = 4'd9; bus.col_b = 4'd1;
            end
            if (chg && c == 6) bus.start = 1'b0;
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_outs("abort_reset_outputs", c, sample(), '0);
`ifdef TPU_PERF_CNT_EN
                check_int("abort_perf_cleared", int'(bus.perf_cycles), 0);
`endif
                seen = 0;
                for (int j = 0; j < 30; j++) begin
                    @(negedge clk);
                    if (bus.done || bus.busy || bus.wr_en_out) seen++;
                end
                check_int("abort_quiet", seen, 0);
                rst_n = 1'b1;
                return;
            end
            act = sample();
            check_outs("cycle_outputs", c, act, model(m, k, p, c % (tot + 2)));
            if (act.done && done_c < 0) done_c = c;
            wr_n   += int'(act.wr);
            clr_n  += int'(act.clr);
            busy_n += int'(act.busy);
        end
`ifdef TPU_PERF_CNT_EN
        check_int("perf_cycles_end", int'(bus.perf_cycles), tot);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int dc, wn, cn, bn;
        int rm, rk, rp;

        bus.start = 1'b0; bus.row_a = '0; bus.k = '0; bus.col_b = '0;
        repeat (3) @(negedge clk);
        check_outs("reset_state", 0, sample(), '0);
`ifdef TPU_PERF_CNT_EN
        check_int("reset_perf", int'(bus.perf_cycles), 0);
`endif
        rst_n = 1'b1;

        vecs[0] = '{4,  4,  4,  1'b0, 17,  4,  1, 18};
        vecs[1] = '{5,  3,  6,  1'b1, 64,  16, 4, 65};
        vecs[2] = '{4,  0,  4,  1'b0, 0,   0,  0, 1};
        vecs[3] = '{1,  1,  1,  1'b0, 14,  4,  1, 15};
        vecs[4] = '{8,  2,  4,  1'b0, 30,  8,  2, 31};
        vecs[5] = '{0,  5,  5,  1'b0, 0,   0,  0, 1};
        vecs[6] = '{15, 15, 15, 1'b0, 448, 64, 16, 449};

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].m, vecs[i].k, vecs[i].p, vecs[i].chg, 1'b0, -1, dc, wn, cn, bn);
            check_int($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            check_int($sformatf("v%0d_writes", i), wn, vecs[i].exp_writes);
            check_int($sformatf("v%0d_clears", i), cn, vecs[i].exp_clears);
            check_int($sformatf("v%0d_busy_cycles", i), bn, vecs[i].exp_busy);
        end

        // start held high through DONE relaunches from IDLE
        run_job(4, 4, 4, 1'b0, 1'b1, -1, dc, wn, cn, bn);
        check_int("hold_writes", wn, 8);
        check_int("hold_clears", cn, 2);

        // reset during WRITE of tile 0 aborts cleanly, then a fresh run
        run_job(4, 4, 4, 1'b0, 1'b0, 14, dc, wn, cn, bn);
        run_job(4, 4, 4, 1'b0, 1'b0, -1, dc, wn, cn, bn);
        check_int("post_abort_done_cycle", dc, 17);

`ifdef TPU_PERF_CNT_EN
        repeat (5) @(negedge clk);
        check_int("perf_held_idle", int'(bus.perf_cycles), 17);
`endif

        for (int i = 0; i < 40; i++) begin
            rm = int'($urandom_range(0, 15));
            rk = int'($urandom_range(0, 15));
            rp = int'($urandom_range(0, 15));
            run_job(rm, rk, rp, 1'b0, 1'b0, -1, dc, wn, cn, bn);
            check_int($sformatf("rnd%0d_done_cycle", i), dc, job_len(rm, rk, rp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
